atcaxi2tluh500_rsp_route: RTL and testbench

Response router for the AXI-to-TL-UH bridge; the return-path counterpart of the fixed-priority request arbiter. On each granted request it records, per TL source tag, which of the N upstream requesters won. On each TL D-channel response it looks the tag up, steers the beat to that requester through a one-deep registered stage, and frees the tag on the last beat. It sits between the D-channel receiver and the N per-requester response ports.

---
 rtl/atcaxi2tluh500_pkg.sv | 23 ++
 rtl/atcaxi2tluh500_oh2bin.sv | 23 ++
 rtl/atcaxi2tluh500_rsp_route.sv | 154 +++++++++++++++
 tb/tb_atcaxi2tluh500_rsp_route.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atcaxi2tluh500_pkg.sv
// Shared types and helpers for the AXI-to-TL-UH bridge response path.
// Imported by the response router and its one-hot encoder.
package atcaxi2tluh500_pkg;

    // Ceiling log2, used to size requester indices and tag tables.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Classification of the D-channel beat presented in the current cycle.
    typedef enum logic [1:0] {
        BEAT_NONE,
        BEAT_STALL,
        BEAT_ROUTE,
        BEAT_DROP
    } beat_e;

endpackage

// File: rtl/atcaxi2tluh500_oh2bin.sv
// One-hot to binary encoder built as an OR-reduction.
// The result is meaningful only when at most one input bit is set.
module atcaxi2tluh500_oh2bin
    import atcaxi2tluh500_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  oh_i,
    output logic [IW-1:0] bin_o
);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N; i++) begin
            if (oh_i[i]) begin
                bin_o = bin_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/atcaxi2tluh500_rsp_route.sv
// Response router: remembers which requester owns each TL source tag and
// steers D-channel beats to that requester through a one-deep output register.
module atcaxi2tluh500_rsp_route
    import atcaxi2tluh500_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? clog2(N) : 1,
    parameter int TW = 3,
    parameter int DW = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_grant,
    input  logic                 req_fire,
    input  logic [TW-1:0]        req_tag,
    output logic [(1<<TW)-1:0]   tag_busy,
    input  logic                 dn_valid,
    output logic                 dn_ready,
    input  logic [TW-1:0]        dn_tag,
    input  logic                 dn_last,
    input  logic [DW-1:0]        dn_data,
    output logic [N-1:0]         up_valid,
    input  logic [N-1:0]         up_ready,
    output logic [DW-1:0]        up_data,
    output logic                 up_last,
    input  logic                 err_clr,
    output logic                 err_unalloc,
    output logic                 err_realloc
);

    localparam int DEPTH = 1 << TW;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IW-1:0]    idx_q [DEPTH];
    logic [IW-1:0]    grant_idx;

    logic             ov_q, ov_d;
    logic [IW-1:0]    oidx_q, oidx_d;
    logic [DW-1:0]    odata_q, odata_d;
    logic             olast_q, olast_d;

    logic             err_unalloc_q, err_unalloc_d;
    logic             err_realloc_q, err_realloc_d;

    beat_e            beat;
    logic             up_fire;
    logic             free_en;
    logic             same_tag_free;
    logic             alloc_en;
    logic             realloc_err;

    atcaxi2tluh500_oh2bin #(
        .N  (N),
        .IW (IW)
    ) u_grant_enc (
        .oh_i  (req_grant),
        .bin_o (grant_idx)
    );

    // Ready passes straight through from the selected requester so a full
    // register can still accept a new beat in the cycle it drains.
    assign up_fire  = ov_q & up_ready[oidx_q];
    assign dn_ready = ~ov_q | up_ready[oidx_q];

    always_comb begin
        beat = BEAT_NONE;
        if (dn_valid) begin
            if (!dn_ready) begin
                beat = BEAT_STALL;
            end else if (vld_q[dn_tag]) begin
                beat = BEAT_ROUTE;
            end else begin
                beat = BEAT_DROP;
            end
        end
    end

    // A last beat freeing the very tag being re-allocated is not a conflict.
    assign free_en       = (beat == BEAT_ROUTE) & dn_last;
    assign same_tag_free = free_en & (dn_tag == req_tag);
    assign alloc_en      = req_fire & (|req_grant) & (~vld_q[req_tag] | same_tag_free);
    assign realloc_err   = req_fire & ~alloc_en;

    always_comb begin
        vld_d = vld_q;
        if (free_en) begin
            vld_d[dn_tag] = 1'b0;
        end
        if (alloc_en) begin
            vld_d[req_tag] = 1'b1;
        end
    end

    always_comb begin
        ov_d    = ov_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        olast_d = olast_q;
        if (beat == BEAT_ROUTE) begin
            ov_d    = 1'b1;
            oidx_d  = idx_q[dn_tag];
            odata_d = dn_data;
            olast_d = dn_last;
        end else if (up_fire) begin
            ov_d = 1'b0;
        end
    end

    // A set in the same cycle as a clear leaves the flag set.
    assign err_unalloc_d = (beat == BEAT_DROP) | (err_unalloc_q & ~err_clr);
    assign err_realloc_d = realloc_err | (err_realloc_q & ~err_clr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q         <= '0;
            ov_q          <= 1'b0;
            oidx_q        <= '0;
            odata_q       <= '0;
            olast_q       <= 1'b0;
            err_unalloc_q <= 1'b0;
            err_realloc_q <= 1'b0;
        end else begin
            vld_q         <= vld_d;
            ov_q          <= ov_d;
            oidx_q        <= oidx_d;
            odata_q       <= odata_d;
            olast_q       <= olast_d;
            err_unalloc_q <= err_unalloc_d;
            err_realloc_q <= err_realloc_d;
        end
    end

    // NOTE: the owner array is not reset; each entry is qualified by its vld bit.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            idx_q[req_tag] <= grant_idx;
        end
    end

    assign tag_busy    = vld_q;
    assign up_valid    = ov_q ? (N'(1) << oidx_q) : '0;
    assign up_data     = odata_q;
    assign up_last     = olast_q;
    assign err_unalloc = err_unalloc_q;
    assign err_realloc = err_realloc_q;

    a_up_valid_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(up_valid));

    a_hold_until_fire : assert property (@(posedge clk) disable iff (reset)
        (ov_q && !up_fire) |=> (ov_q && $stable(odata_q) && $stable(olast_q) && $stable(oidx_q)));

endmodule

// File: tb/tb_atcaxi2tluh500_rsp_route.sv
// Self-checking bench for the response router: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a tag-table model.
module tb_atcaxi2tluh500_rsp_route;

    localparam int N     = 8;
    localparam int TW    = 3;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << TW;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_grant;
    logic             req_fire;
    logic [TW-1:0]    req_tag;
    logic [DEPTH-1:0] tag_busy;
    logic             dn_valid;
    logic             dn_ready;
    logic [TW-1:0]    dn_tag;
    logic             dn_last;
    logic [DW-1:0]    dn_data;
    logic [N-1:0]     up_valid;
    logic [N-1:0]     up_ready;
    logic [DW-1:0]    up_data;
    logic             up_last;
    logic             err_clr;
    logic             err_unalloc;
    logic             err_realloc;

    atcaxi2tluh500_rsp_route #(
        .N  (N),
        .IW (3),
        .TW (TW),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_grant   (req_grant),
        .req_fire    (req_fire),
        .req_tag     (req_tag),
        .tag_busy    (tag_busy),
        .dn_valid    (dn_valid),
        .dn_ready    (dn_ready),
        .dn_tag      (dn_tag),
        .dn_last     (dn_last),
        .dn_data     (dn_data),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_last     (up_last),
        .err_clr     (err_clr),
        .err_unalloc (err_unalloc),
        .err_realloc (err_realloc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a tag -> owner map, one pending upstream beat, two sticky flags.
    bit          m_busy  [DEPTH];
    int          m_owner [DEPTH];
    bit          m_ov;
    int          m_idx;
    logic [DW-1:0] m_data;
    bit          m_last;
    bit          m_eu;
    bit          m_er;
    bit          cmp_en = 1'b0;

    bit          t_rdy, t_fire, t_hit, t_upf, t_eu_set, t_er_set;
    int          t_gidx;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            m_ov   = 1'b0;
            m_idx  = 0;
            m_data = '0;
            m_last = 1'b0;
            m_eu   = 1'b0;
            m_er   = 1'b0;
        end else begin
            t_rdy    = !m_ov || up_ready[m_idx];
            t_upf    = m_ov && up_ready[m_idx];
            t_fire   = dn_valid && t_rdy;
            t_hit    = m_busy[dn_tag];
            t_eu_set = t_fire && !t_hit;
            t_er_set = 1'b0;
            if (t_fire && t_hit) begin
                m_ov   = 1'b1;
                m_idx  = m_owner[dn_tag];
                m_data = dn_data;
                m_last = dn_last;
                if (dn_last) m_busy[dn_tag] = 1'b0;
            end else if (t_upf) begin
                m_ov = 1'b0;
            end
            // Applying the free first makes a same-cycle re-allocation legal.
            t_gidx = -1;
            for (int i = 0; i < N; i++) if (req_grant[i]) t_gidx = i;
            if (req_fire) begin
                if (t_gidx >= 0 && !m_busy[req_tag]) begin
                    m_busy[req_tag]  = 1'b1;
                    m_owner[req_tag] = t_gidx;
                end else begin
                    t_er_set = 1'b1;
                end
            end
            m_eu = t_eu_set || (m_eu && !err_clr);
            m_er = t_er_set || (m_er && !err_clr);
        end
    end

    logic [N-1:0]     e_valid;
    logic [DEPTH-1:0] e_busy;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_valid = m_ov ? (N'(1) << m_idx) : '0;
            for (int i = 0; i < DEPTH; i++) e_busy[i] = m_busy[i];
            check("up_valid", 64'(up_valid), 64'(e_valid));
            check("up_data", up_data, m_data);
            check("up_last", 64'(up_last), 64'(m_last));
            check("dn_ready", 64'(dn_ready), 64'(!m_ov || up_ready[m_idx]));
            check("tag_busy", 64'(tag_busy), 64'(e_busy));
            check("err_unalloc", 64'(err_unalloc), 64'(m_eu));
            check("err_realloc", 64'(err_realloc), 64'(m_er));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_grant = '0;
        req_fire  = 1'b0;
        req_tag   = '0;
        dn_valid  = 1'b0;
        dn_tag    = '0;
        dn_last   = 1'b0;
        dn_data   = '0;
        err_clr   = 1'b0;
    endtask

    task automatic alloc(input logic [TW-1:0] tag, input logic [N-1:0] grant);
        req_fire  = 1'b1;
        req_tag   = tag;
        req_grant = grant;
        tick();
        req_fire  = 1'b0;
        req_grant = '0;
    endtask

    // Presents one beat and holds it until accepted, within a cycle budget.
    task automatic send_beat(input logic [TW-1:0] tag, input logic last, input logic [DW-1:0] data);
        bit done;
        done     = 1'b0;
        dn_valid = 1'b1;
        dn_tag   = tag;
        dn_last  = last;
        dn_data  = data;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            done = dn_ready;
            tick();
        end
        dn_valid = 1'b0;
        if (!done) check("beat_timeout", 64'd0, 64'd1);
    endtask

    int pick;

    initial begin
        idle_inputs();
        up_ready = '1;
        reset    = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;
        reset  = 1'b0;
        check("rst_dn_ready", 64'(dn_ready), 64'd1);
        check("rst_up_valid", 64'(up_valid), 64'd0);
        check("rst_up_data", up_data, 64'd0);
        check("rst_tag_busy", 64'(tag_busy), 64'd0);
        check("rst_errs", 64'({err_unalloc, err_realloc}), 64'd0);

        // Allocate tag 3 to requester 2, then a single-beat response.
        alloc(3'd3, 8'b0000_0100);
        check("alloc_busy", 64'(tag_busy), 64'h08);
        send_beat(3'd3, 1'b1, 64'hA5);
        check("route_valid", 64'(up_valid), 64'h04);
        check("route_data", up_data, 64'hA5);
        check("route_free", 64'(tag_busy), 64'h00);
        tick();
        check("route_drain", 64'(up_valid), 64'h00);

        // Four beats on tag 1 with requester 0 stalled for two cycles.
        alloc(3'd1, 8'b0000_0001);
        up_ready = 8'hFE;
        send_beat(3'd1, 1'b0, 64'h10);
        dn_valid = 1'b1;
        dn_data  = 64'h11;
        #1;
        check("bp_ready0", 64'(dn_ready), 64'd0);
        check("bp_hold0", up_data, 64'h10);
        tick();
        check("bp_ready1", 64'(dn_ready), 64'd0);
        check("bp_hold1", up_data, 64'h10);
        tick();
        up_ready = 8'hFF;
        #1;
        check("bp_release", 64'(dn_ready), 64'd1);
        tick();
        check("bp_beat1", up_data, 64'h11);
        dn_data = 64'h12;
        tick();
        check("bp_beat2", up_data, 64'h12);
        dn_last = 1'b1;
        dn_data = 64'h13;
        tick();
        dn_valid = 1'b0;
        dn_last  = 1'b0;
        check("bp_beat3", up_data, 64'h13);
        check("bp_last", 64'(up_last), 64'd1);
        check("bp_free", 64'(tag_busy), 64'h00);
        tick();
        check("bp_drain", 64'(up_valid), 64'h00);

        // Beat on a free tag is swallowed and flagged.
        dn_valid = 1'b1;
        dn_tag   = 3'd5;
        dn_last  = 1'b1;
        dn_data  = 64'h55;
        #1;
        check("unalloc_ready", 64'(dn_ready), 64'd1);
        tick();
        dn_valid = 1'b0;
        check("unalloc_novalid", 64'(up_valid), 64'h00);
        check("unalloc_flag", 64'(err_unalloc), 64'd1);
        tick();
        check("unalloc_sticky", 64'(err_unalloc), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unalloc_clr", 64'(err_unalloc), 64'd0);

        // Re-allocating a busy tag keeps the original owner.
        alloc(3'd2, 8'b0000_0010);
        alloc(3'd2, 8'b0001_0000);
        check("realloc_flag", 64'(err_realloc), 64'd1);
        check("realloc_busy", 64'(tag_busy), 64'h04);
        send_beat(3'd2, 1'b1, 64'h22);
        check("realloc_owner", 64'(up_valid), 64'h02);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("realloc_clr", 64'(err_realloc), 64'd0);

        // Last beat and new allocation on tag 6 in the same cycle.
        alloc(3'd6, 8'b0000_1000);
        req_fire  = 1'b1;
        req_tag   = 3'd6;
        req_grant = 8'h80;
        send_beat(3'd6, 1'b1, 64'h66);
        req_fire  = 1'b0;
        req_grant = '0;
        check("swap_busy", 64'(tag_busy), 64'h40);
        check("swap_old_owner", 64'(up_valid), 64'h08);
        check("swap_no_err", 64'(err_realloc), 64'd0);
        tick();
        send_beat(3'd6, 1'b1, 64'h77);
        check("swap_new_owner", 64'(up_valid), 64'h80);
        check("swap_new_data", up_data, 64'h77);
        tick();

        // Reset between beats two and three of a response.
        alloc(3'd4, 8'b0010_0000);
        send_beat(3'd4, 1'b0, 64'h41);
        send_beat(3'd4, 1'b0, 64'h42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 64'(up_valid), 64'h00);
        check("mid_rst_data", up_data, 64'h00);
        check("mid_rst_busy", 64'(tag_busy), 64'h00);
        check("mid_rst_ready", 64'(dn_ready), 64'd1);
        send_beat(3'd4, 1'b1, 64'h43);
        check("mid_rst_unalloc", 64'(err_unalloc), 64'd1);
        check("mid_rst_dropped", 64'(up_valid), 64'h00);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            up_ready = N'($urandom);
            if ($urandom_range(0, 3) == 0) up_ready = '1;
            req_fire = ($urandom_range(0, 3) == 0);
            pick     = $urandom_range(0, 9);
            req_grant = (pick >= N) ? '0 : (N'(1) << pick);
            req_tag  = TW'($urandom);
            dn_valid = $urandom_range(0, 1);
            dn_tag   = TW'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                pick = $urandom_range(0, DEPTH - 1);
                for (int k = 0; k < DEPTH; k++) begin
                    if (m_busy[(pick + k) % DEPTH]) begin
                        dn_tag = TW'((pick + k) % DEPTH);
                        break;
                    end
                end
            end
            dn_last = ($urandom_range(0, 2) == 0);
            dn_data = {$urandom, $urandom};
            err_clr = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end

        idle_inputs();
        reset    = 1'b0;
        up_ready = '1;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
